// File: rtl/icache_tag_ram.sv
// icache_tag_ram
//   Simple dual-port tag RAM for the instruction cache: one write port on
//   wr_clk, one registered read port on rd_clk. Read data has 1-cycle
//   latency, or 2 cycles when OUTPUT_REG=1. Reads are read-first on
//   coincident same-address collisions.
//
// Ports
//   wr_clk     write-port clock
//   tb_wr_rst  write-port reset, active-high (style set by RESET_TYPE)
//   rd_clk     read-port clock
//   rd_rst     read-port reset, active-high (style set by RESET_TYPE)
//   wr_en      write enable
//   wr_addr    write address
//   wr_data    write data (full word, no byte enables)
//   rd_addr    read address, sampled on every rd_clk edge
//   rd_data    registered read data
module icache_tag_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 21,
  parameter int OUTPUT_REG = 0,
  parameter     RESET_TYPE = "ASYNC"
) (
  input  logic                  wr_clk,
  input  logic                  tb_wr_rst,
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit SYNC_RST = (RESET_TYPE == "SYNC");
  localparam bit SYNC_REL = (RESET_TYPE == "ASYNC_SYNC_RELEASE");

  // Neither reset touches the array; it only starts out cleared.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic                  wr_rst_eff;
  logic                  rd_rst_eff;
  logic [DATA_WIDTH-1:0] rd_q;

  // Reset conditioning: either the raw pin, or a version that asserts
  // immediately but releases two clock edges after the pin drops.
  if (SYNC_REL) begin : g_wr_rel
    logic [1:0] wr_rst_sync;
    always_ff @(posedge wr_clk or posedge tb_wr_rst) begin
      if (tb_wr_rst) wr_rst_sync <= 2'b11;
      else           wr_rst_sync <= {wr_rst_sync[0], 1'b0};
    end
    assign wr_rst_eff = wr_rst_sync[1];
  end else begin : g_wr_direct
    assign wr_rst_eff = tb_wr_rst;
  end

  if (SYNC_REL) begin : g_rd_rel
    logic [1:0] rd_rst_sync;
    always_ff @(posedge rd_clk or posedge rd_rst) begin
      if (rd_rst) rd_rst_sync <= 2'b11;
      else        rd_rst_sync <= {rd_rst_sync[0], 1'b0};
    end
    assign rd_rst_eff = rd_rst_sync[1];
  end else begin : g_rd_direct
    assign rd_rst_eff = rd_rst;
  end

  // Write port. The reset only gates the enable, so the level sampled at
  // the edge is all that matters regardless of RESET_TYPE.
  always_ff @(posedge wr_clk) begin
    if (wr_en && !wr_rst_eff) mem[wr_addr] <= wr_data;
  end

  // Read port. The non-blocking write above guarantees read-first when the
  // two clocks share an edge; with unrelated clocks the whole word is
  // captured either before or after the write.
  if (SYNC_RST) begin : g_rd_sync
    always_ff @(posedge rd_clk) begin
      if (rd_rst_eff) rd_q <= '0;
      else            rd_q <= mem[rd_addr];
    end
  end else begin : g_rd_async
    always_ff @(posedge rd_clk or posedge rd_rst_eff) begin
      if (rd_rst_eff) rd_q <= '0;
      else            rd_q <= mem[rd_addr];
    end
  end

  if (OUTPUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] rd_q2;
    if (SYNC_RST) begin : g_sync
      always_ff @(posedge rd_clk) begin
        if (rd_rst_eff) rd_q2 <= '0;
        else            rd_q2 <= rd_q;
      end
    end else begin : g_async
      always_ff @(posedge rd_clk or posedge rd_rst_eff) begin
        if (rd_rst_eff) rd_q2 <= '0;
        else            rd_q2 <= rd_q;
      end
    end
    assign rd_data = rd_q2;
  end else begin : g_no_out_reg
    assign rd_data = rd_q;
  end

endmodule

// File: tb/tb_icache_tag_ram.sv
// tb_icache_tag_ram
//   Bench for icache_tag_ram. Two instances share every input: dut0 with
//   the default 1-cycle read latency and dut1 with OUTPUT_REG=1. Both
//   clocks run at the same period and phase so collisions are coincident.
module tb_icache_tag_ram;

  logic        wr_clk = 1'b0;
  logic        rd_clk = 1'b0;
  logic        tb_wr_rst;
  logic        rd_rst;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [20:0] wr_data;
  logic [7:0]  rd_addr;
  logic [20:0] rd_data0;
  logic [20:0] rd_data1;

  logic [20:0] model_mem [256];
  int checks = 0;
  int errors = 0;

  always #5 wr_clk = ~wr_clk;
  always #5 rd_clk = ~rd_clk;

  icache_tag_ram #(.OUTPUT_REG(0)) dut0 (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .rd_clk(rd_clk), .rd_rst(rd_rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data0)
  );

  icache_tag_ram #(.OUTPUT_REG(1)) dut1 (
    .wr_clk(wr_clk), .tb_wr_rst(tb_wr_rst), .rd_clk(rd_clk), .rd_rst(rd_rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1)
  );

  // Scoreboarded read sweep: expected word is queued when the address is
  // driven and popped once the selected output has had `lat` edges.
  task automatic read_sweep(input int first, input int last, input int lat);
    logic [20:0] exp_q [$];
    logic [20:0] got;
    logic [20:0] exp;
    int n;
    n = last - first + 1;
    for (int c = 0; c < n + lat; c++) begin
      @(negedge rd_clk);
      if (c >= lat) begin
        exp = exp_q.pop_front();
        got = (lat == 2) ? rd_data1 : rd_data0;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL sweep_rd lat=%0d addr=%02h got=%06h exp=%06h",
                   lat, first + c - lat, got, exp);
        end
      end
      if (c < n) begin
        rd_addr = 8'(first + c);
        exp_q.push_back(model_mem[first + c]);
      end
    end
  endtask

  task automatic write_sweep();
    for (int i = 0; i < 256; i++) begin
      @(negedge wr_clk);
      wr_en   = 1'b1;
      wr_addr = 8'(i);
      wr_data = 21'h1FFFFF - 21'(i);
      model_mem[i] = 21'h1FFFFF - 21'(i);
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    tb_wr_rst = 1'b1;
    rd_rst    = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 8'h05;
    wr_data   = 21'h15555;
    rd_addr   = 8'h05;
    for (int i = 0; i < 20; i++) begin
      @(negedge rd_clk);
      checks++;
      if (rd_data0 !== 21'h0 || rd_data1 !== 21'h0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got0=%06h got1=%06h exp=0", i, rd_data0, rd_data1);
      end
    end
    tb_wr_rst = 1'b0;
    rd_rst    = 1'b0;
    wr_en     = 1'b0;
    checks++;
    #1;
    if (rd_data0 !== 21'h0) begin
      errors++;
      $display("FAIL reset_release got=%06h exp=0", rd_data0);
    end
    // Address 5 was written only while in reset, so it must still read zero.
    read_sweep(5, 5, 1);
  endtask

  task automatic test_full_sweep();
    write_sweep();
    read_sweep(0, 255, 1);
  endtask

  task automatic test_hold_last();
    @(negedge wr_clk);
    wr_en   = 1'b0;
    wr_addr = 8'h10;
    wr_data = 21'h00ABC;
    repeat (2) @(negedge wr_clk);
    @(negedge rd_clk);
    rd_addr = 8'h10;
    @(negedge rd_clk);
    checks++;
    if (rd_data0 !== 21'h1FFFEF) begin
      errors++;
      $display("FAIL hold_last got=%06h exp=1fffef", rd_data0);
    end
  endtask

  task automatic test_collision();
    @(negedge wr_clk);
    wr_en   = 1'b1;
    wr_addr = 8'h20;
    wr_data = 21'h012345;
    model_mem[8'h20] = 21'h012345;
    @(negedge wr_clk);
    wr_en = 1'b0;
    @(negedge wr_clk);
    wr_en   = 1'b1;
    wr_data = 21'h054321;
    rd_addr = 8'h20;
    @(negedge wr_clk);
    wr_en = 1'b0;
    checks++;
    if (rd_data0 !== 21'h012345) begin
      errors++;
      $display("FAIL collision_old got=%06h exp=012345", rd_data0);
    end
    model_mem[8'h20] = 21'h054321;
    @(negedge rd_clk);
    checks++;
    if (rd_data0 !== 21'h054321) begin
      errors++;
      $display("FAIL collision_new got=%06h exp=054321", rd_data0);
    end
    checks++;
    if (rd_data1 !== 21'h012345) begin
      errors++;
      $display("FAIL collision_old_lat2 got=%06h exp=012345", rd_data1);
    end
  endtask

  task automatic test_mid_read_reset();
    read_sweep(0, 63, 1);
    // Pulse lands between clock edges so only an asynchronous clear passes.
    #2;
    rd_rst = 1'b1;
    #1;
    checks++;
    if (rd_data0 !== 21'h0 || rd_data1 !== 21'h0) begin
      errors++;
      $display("FAIL rd_rst_async got0=%06h got1=%06h exp=0", rd_data0, rd_data1);
    end
    @(posedge rd_clk);
    #1;
    checks++;
    if (rd_data0 !== 21'h0) begin
      errors++;
      $display("FAIL rd_rst_hold got=%06h exp=0", rd_data0);
    end
    @(negedge rd_clk);
    rd_rst = 1'b0;
    #1;
    checks++;
    if (rd_data0 !== 21'h0) begin
      errors++;
      $display("FAIL rd_rst_release got=%06h exp=0", rd_data0);
    end
    read_sweep(0, 255, 1);
  endtask

  task automatic test_output_reg();
    write_sweep();
    read_sweep(0, 255, 2);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) model_mem[i] = 21'h0;
    test_reset();
    test_full_sweep();
    test_hold_last();
    test_collision();
    test_mid_read_reset();
    test_output_reg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
